ece2300_test_source: RTL and testbench

ECE2300_TEST_SOURCE -- requirements
Module: ece2300_test_source

---
 rtl/ece2300_test_source.sv | 201 ++++++++++++++++++++
 tb/tb_ece2300_test_source.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ece2300_test_source.sv
// Test source: streams num_msgs preloaded messages from a small memory over a val/rdy port.
// Latency: first message valid the cycle after start; one message per cycle when out_rdy=1.
// Backpressure: out_msg/out_val hold until out_rdy; a run aborts with timeout after p_timeout busy cycles.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   load_en/load_addr/load_data  memory write port (accepted only in IDLE/DONE)
//   num_msgs, start          run length (clamped to p_num_msgs) and run trigger
//   out_val/out_rdy/out_msg  stimulus stream
//   busy, done, timeout, sent_count  run status
//
// Optional feature: define ECE2300_TEST_SOURCE_RAND_DELAY_EN to insert
// LFSR-driven 0..3 cycle gaps before every message.

module ece2300_test_source #(
  parameter int p_msg_nbits = 8,
  parameter int p_num_msgs  = 16,
  parameter int p_timeout   = 10000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_en,
  input  logic [$clog2(p_num_msgs)-1:0]  load_addr,
  input  logic [p_msg_nbits-1:0]         load_data,
  input  logic [$clog2(p_num_msgs):0]    num_msgs,
  input  logic                           start,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_nbits-1:0]         out_msg,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [$clog2(p_num_msgs):0]    sent_count
);

  localparam int AW = $clog2(p_num_msgs);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(p_timeout + 1);

  typedef enum logic [1:0] {IDLE, DELAY, SEND, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [p_msg_nbits-1:0] mem [p_num_msgs];
  logic [AW-1:0]          index;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          num_clamp;
  logic [TW-1:0]          cyc;

  logic                   idle_like;
  logic                   start_ok;
  logic                   xfer;
  logic                   last;
  logic                   cyc_hit;
  logic                   enter_msg;
  logic [1:0]             dly;
  logic [1:0]             dly_cnt;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign start_ok  = start && idle_like;
  assign xfer      = (state == SEND) && out_rdy;
  assign last      = ((sent_count + CW'(1)) == count_r);
  assign cyc_hit   = ((cyc + TW'(1)) == TW'(p_timeout));
  assign num_clamp = (num_msgs > CW'(p_num_msgs)) ? CW'(p_num_msgs) : num_msgs;

  // A new message is about to be presented: either the first one of a run
  // or the next one after a transfer that neither ends the run nor times out.
  assign enter_msg = (start_ok && (num_clamp != '0)) || (xfer && !last && !cyc_hit);

`ifdef ECE2300_TEST_SOURCE_RAND_DELAY_EN
  localparam logic [31:0] LFSR_SEED = 32'hdeadbeef;

  logic [31:0] lfsr;
  logic [31:0] lfsr_src;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  // A start reseeds, so the first gap of every run comes from the seed itself.
  assign lfsr_src = start_ok ? LFSR_SEED : lfsr;
  assign dly      = lfsr_src[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= LFSR_SEED;
      dly_cnt <= 2'd0;
    end else if (enter_msg) begin
      lfsr    <= lfsr_adv(lfsr_src);
      dly_cnt <= dly;
    end else begin
      if (start_ok) begin
        lfsr <= LFSR_SEED;
      end
      if (state == DELAY) begin
        dly_cnt <= dly_cnt - 2'd1;
      end
    end
  end
`else
  // No gaps: DELAY is never entered.
  assign dly     = 2'd0;
  assign dly_cnt = 2'd1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          if (num_clamp == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = (dly != 2'd0) ? DELAY : SEND;
          end
        end
      end
      DELAY: begin
        if (cyc_hit) begin
          state_nxt = DONE;
        end else if (dly_cnt == 2'd1) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (xfer && last) begin
          state_nxt = DONE;
        end else if (cyc_hit) begin
          state_nxt = DONE;
        end else if (xfer) begin
          state_nxt = (dly != 2'd0) ? DELAY : SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_val = 1'b0;
    out_msg = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      DELAY: busy = 1'b1;
      SEND: begin
        busy    = 1'b1;
        out_val = 1'b1;
        out_msg = mem[index];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Run bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      index      <= '0;
      sent_count <= '0;
      count_r    <= '0;
      cyc        <= '0;
      timeout    <= 1'b0;
    end else if (start_ok) begin
      index      <= '0;
      sent_count <= '0;
      count_r    <= num_clamp;
      cyc        <= '0;
      timeout    <= 1'b0;
    end else if (busy) begin
      cyc <= cyc + TW'(1);
      if (xfer) begin
        sent_count <= sent_count + CW'(1);
        index      <= index + AW'(1);
      end
      // A transfer that completes the run on the final cycle wins over the abort.
      if (cyc_hit && !(xfer && last)) begin
        timeout <= 1'b1;
      end
    end
  end

  // Message memory: no reset so contents survive rst; writes only while not running.
  always_ff @(posedge clk) begin
    if (!rst && load_en && idle_like) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_ece2300_test_source.sv
module tb_ece2300_test_source;

  localparam int MW = 8;
  localparam int NM = 16;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [4:0] num_msgs;
  logic       start;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [4:0] sent_count;

  always #5 clk = ~clk;

  ece2300_test_source #(.p_msg_nbits(MW), .p_num_msgs(NM), .p_timeout(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .num_msgs   (num_msgs),
    .start      (start),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .sent_count (sent_count)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- Reference model (transaction level) ----------------
  logic [7:0] m_mem [NM];
  logic [7:0] m_q [$];
  bit         m_run  = 1'b0;
  bit         m_done = 1'b0;
  bit         m_to   = 1'b0;
  int         m_cnt  = 0;
  int         m_cyc  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       busy,       m_run);
      chk("done",       done,       m_done);
      chk("timeout",    timeout,    m_to);
      chk("sent_count", sent_count, m_cnt);
      chk("out_val",    out_val,    m_run);
      chk("out_msg",    out_msg,    m_run ? m_q[0] : 8'h00);
    end
    if (rst) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_to   = 1'b0;
      m_cnt  = 0;
      m_q.delete();
    end else if (m_run) begin
      m_cyc++;
      if (out_rdy) begin
        void'(m_q.pop_front());
        m_cnt++;
      end
      if (m_q.size() == 0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else if (m_cyc == TO) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_to   = 1'b1;
        m_q.delete();
      end
    end else begin
      if (load_en) m_mem[load_addr] = load_data;
      if (start) begin
        int n;
        n = (int'(num_msgs) > NM) ? NM : int'(num_msgs);
        m_to  = 1'b0;
        m_cnt = 0;
        m_cyc = 0;
        m_q.delete();
        for (int i = 0; i < n; i++) m_q.push_back(m_mem[i]);
        if (n == 0) begin
          m_done = 1'b1;
        end else begin
          m_run  = 1'b1;
          m_done = 1'b0;
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic kick(input logic [4:0] n);
    num_msgs = n;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    num_msgs  = '0;
    start     = 1'b0;
    out_rdy   = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst_busy",    busy,       0);
    chk("rst_done",    done,       0);
    chk("rst_val",     out_val,    0);
    chk("rst_msg",     out_msg,    0);
    chk("rst_timeout", timeout,    0);
    chk("rst_sent",    sent_count, 0);
    tick();
    rst = 1'b0;

    load(4'd0, 8'h11);
    load(4'd1, 8'h22);
    load(4'd2, 8'h33);
    load(4'd3, 8'h44);
    for (int i = 4; i < NM; i++) load(4'(i), 8'(8'h50 + i));

    // Four back-to-back messages
    out_rdy = 1'b1;
    kick(5'd4);
    chk("seq_m0", out_msg, 8'h11);
    tick(); chk("seq_m1", out_msg, 8'h22);
    tick(); chk("seq_m2", out_msg, 8'h33);
    tick(); chk("seq_m3", out_msg, 8'h44);
    tick();
    chk("seq_done", done, 1);
    chk("seq_cnt",  sent_count, 4);
    chk("seq_val",  out_val, 0);

    // Stall three cycles on 0x22; stray start and load during run are ignored
    kick(5'd4);
    chk("stl_m0", out_msg, 8'h11);
    tick();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stl_val", out_val, 1);
      chk("stl_msg", out_msg, 8'h22);
      if (i == 1) begin
        start = 1'b1; num_msgs = 5'd1;
        load_en = 1'b1; load_addr = 4'd1; load_data = 8'h99;
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      tick();
    end
    out_rdy = 1'b1;
    chk("stl_m1", out_msg, 8'h22);
    tick(); chk("stl_m2", out_msg, 8'h33);
    tick(); chk("stl_m3", out_msg, 8'h44);
    tick();
    chk("stl_done", done, 1);
    chk("stl_cnt",  sent_count, 4);

    // Empty run
    kick(5'd0);
    chk("zero_done", done, 1);
    chk("zero_cnt",  sent_count, 0);
    chk("zero_val",  out_val, 0);

    // Timeout with downstream never ready
    out_rdy = 1'b0;
    kick(5'd4);
    for (int i = 0; i < TO; i++) begin
      chk("to_busy", busy, 1);
      tick();
    end
    chk("to_flag", timeout, 1);
    chk("to_done", done, 1);
    chk("to_val",  out_val, 0);

    // Next start clears timeout
    out_rdy = 1'b1;
    kick(5'd2);
    chk("clr_to", timeout, 0);
    chk("clr_m0", out_msg, 8'h11);
    tick(); tick();
    chk("clr_cnt", sent_count, 2);

    // Reset after second transfer, with start and load in the same cycle
    kick(5'd4);
    tick();
    tick();
    chk("rr_cnt2", sent_count, 2);
    rst = 1'b1; start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 8'hee;
    tick();
    rst = 1'b0; start = 1'b0; load_en = 1'b0;
    chk("rr_val",  out_val, 0);
    chk("rr_cnt",  sent_count, 0);
    chk("rr_busy", busy, 0);
    kick(5'd4);
    chk("rr_m0", out_msg, 8'h11);
    tick(); chk("rr_m1", out_msg, 8'h22);
    tick(); tick(); tick();
    chk("rr_done", done, 1);

    // Clamp of oversize count
    kick(5'd20);
    begin
      int k;
      k = 0;
      while (!done && k < 40) begin
        tick();
        k++;
      end
      chk("clamp_finish", done, 1);
    end
    chk("clamp_cnt", sent_count, 16);

    // Single message
    kick(5'd1);
    chk("one_m0", out_msg, 8'h11);
    tick();
    chk("one_done", done, 1);
    chk("one_cnt",  sent_count, 1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
